// File: rtl/sdram_arbiter_if.sv
// Bundle of the two requester ports and the shared controller port around sdram_arbiter.
// slave is the arbiter's view; master is the surrounding logic's view.
interface sdram_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned MASK_WIDTH = 2
);
   logic                  h_critical;
   logic                  h_enable;
   logic                  h_we;
   logic [ADDR_WIDTH-1:0] h_addr;
   logic [DATA_WIDTH-1:0] h_wr_data;
   logic [MASK_WIDTH-1:0] h_wr_mask;
   logic                  h_refresh_inhibit;
   logic                  h_ack;
   logic                  l_enable;
   logic                  l_we;
   logic [ADDR_WIDTH-1:0] l_addr;
   logic [DATA_WIDTH-1:0] l_wr_data;
   logic [MASK_WIDTH-1:0] l_wr_mask;
   logic                  l_ack;
   logic                  l_idle;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  sd_acc;
   logic                  sd_we;
   logic [ADDR_WIDTH-1:0] sd_addr;
   logic [DATA_WIDTH-1:0] sd_wr_data;
   logic [MASK_WIDTH-1:0] sd_sel;
   logic                  sd_ack_level;
   logic [DATA_WIDTH-1:0] sd_rd_data;
   logic                  sd_idle;
   logic                  sd_refresh_inhibit;
   logic                  inhibit_overrun;

   modport slave (
      input  h_critical, h_enable, h_we, h_addr, h_wr_data, h_wr_mask, h_refresh_inhibit,
      input  l_enable, l_we, l_addr, l_wr_data, l_wr_mask,
      input  sd_ack_level, sd_rd_data, sd_idle,
      output h_ack, l_ack, l_idle, rd_data,
      output sd_acc, sd_we, sd_addr, sd_wr_data, sd_sel, sd_refresh_inhibit, inhibit_overrun
   );

   modport master (
      output h_critical, h_enable, h_we, h_addr, h_wr_data, h_wr_mask, h_refresh_inhibit,
      output l_enable, l_we, l_addr, l_wr_data, l_wr_mask,
      output sd_ack_level, sd_rd_data, sd_idle,
      input  h_ack, l_ack, l_idle, rd_data,
      input  sd_acc, sd_we, sd_addr, sd_wr_data, sd_sel, sd_refresh_inhibit, inhibit_overrun
   );
endinterface

// File: rtl/sdram_arbiter.sv
// Registered two-port arbiter (H high priority, L low priority) in front of sdram_ctrl,
// with ack routing and a watchdog bounding how long refresh may be inhibited.
module sdram_arbiter #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned MASK_WIDTH  = 2,
   parameter int unsigned INHIBIT_MAX = 4096
) (
   input logic          clk,
   input logic          reset,
   sdram_arbiter_if.slave bus
);
   localparam int unsigned CW = (INHIBIT_MAX > 1) ? $clog2(INHIBIT_MAX) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(INHIBIT_MAX - 1);

   typedef enum logic [2:0] {IDLE, BUSY_H, BUSY_L, REL_H, REL_L} state_e;

   state_e                state_q, state_d;
   logic                  sd_acc_q, sd_acc_d;
   logic                  sd_we_q, sd_we_d;
   logic [ADDR_WIDTH-1:0] sd_addr_q, sd_addr_d;
   logic [DATA_WIDTH-1:0] sd_wr_data_q, sd_wr_data_d;
   logic [MASK_WIDTH-1:0] sd_sel_q, sd_sel_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  h_ack_q, h_ack_d;
   logic                  l_ack_q, l_ack_d;
   logic                  l_idle_q, l_idle_d;
   logic                  ack_prev_q;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  ovr_active_q, ovr_active_d;
   logic                  ovr_sticky_q, ovr_sticky_d;
   logic                  ack_rise;
   logic                  inhibit;

   assign ack_rise = bus.sd_ack_level && !ack_prev_q;
   assign inhibit  = !reset && bus.h_critical && bus.h_refresh_inhibit && !ovr_active_q;

   always_comb begin
      state_d      = state_q;
      sd_acc_d     = sd_acc_q;
      sd_we_d      = sd_we_q;
      sd_addr_d    = sd_addr_q;
      sd_wr_data_d = sd_wr_data_q;
      sd_sel_d     = sd_sel_q;
      rd_data_d    = rd_data_q;
      h_ack_d      = 1'b0;
      l_ack_d      = 1'b0;
      l_idle_d     = bus.sd_idle && (state_q == IDLE) && !bus.h_critical;

      unique case (state_q)
         IDLE: begin
            if (bus.h_enable) begin
               sd_acc_d     = 1'b1;
               sd_we_d      = bus.h_we;
               sd_addr_d    = bus.h_addr;
               sd_wr_data_d = bus.h_wr_data;
               sd_sel_d     = bus.h_wr_mask;
               state_d      = BUSY_H;
            end else if (bus.l_enable && !bus.h_critical) begin
               sd_acc_d     = 1'b1;
               sd_we_d      = bus.l_we;
               sd_addr_d    = bus.l_addr;
               sd_wr_data_d = bus.l_wr_data;
               sd_sel_d     = bus.l_wr_mask;
               state_d      = BUSY_L;
            end
         end
         BUSY_H, BUSY_L: begin
            if (ack_rise) begin
               rd_data_d = bus.sd_rd_data;
               sd_acc_d  = 1'b0;
               h_ack_d   = (state_q == BUSY_H);
               l_ack_d   = (state_q == BUSY_L);
               state_d   = (state_q == BUSY_H) ? REL_H : REL_L;
            end
         end
         REL_H: if (!bus.sd_ack_level && !bus.h_enable) state_d = IDLE;
         REL_L: if (!bus.sd_ack_level && !bus.l_enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Counter holds at its last value on the overrun cycle; inhibit drops next cycle and clears it.
      cnt_d        = '0;
      ovr_active_d = ovr_active_q;
      ovr_sticky_d = ovr_sticky_q;
      if (inhibit) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d        = cnt_q;
            ovr_active_d = 1'b1;
            ovr_sticky_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      if (!bus.h_critical) ovr_active_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         sd_acc_q     <= 1'b0;
         sd_we_q      <= 1'b0;
         sd_addr_q    <= '0;
         sd_wr_data_q <= '0;
         sd_sel_q     <= '0;
         rd_data_q    <= '0;
         h_ack_q      <= 1'b0;
         l_ack_q      <= 1'b0;
         l_idle_q     <= 1'b0;
         ack_prev_q   <= 1'b0;
         cnt_q        <= '0;
         ovr_active_q <= 1'b0;
         ovr_sticky_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sd_acc_q     <= sd_acc_d;
         sd_we_q      <= sd_we_d;
         sd_addr_q    <= sd_addr_d;
         sd_wr_data_q <= sd_wr_data_d;
         sd_sel_q     <= sd_sel_d;
         rd_data_q    <= rd_data_d;
         h_ack_q      <= h_ack_d;
         l_ack_q      <= l_ack_d;
         l_idle_q     <= l_idle_d;
         ack_prev_q   <= bus.sd_ack_level;
         cnt_q        <= cnt_d;
         ovr_active_q <= ovr_active_d;
         ovr_sticky_q <= ovr_sticky_d;
      end
   end

   assign bus.h_ack              = h_ack_q;
   assign bus.l_ack              = l_ack_q;
   assign bus.l_idle             = l_idle_q;
   assign bus.rd_data            = rd_data_q;
   assign bus.sd_acc             = sd_acc_q;
   assign bus.sd_we              = sd_we_q;
   assign bus.sd_addr            = sd_addr_q;
   assign bus.sd_wr_data         = sd_wr_data_q;
   assign bus.sd_sel             = sd_sel_q;
   assign bus.sd_refresh_inhibit = inhibit;
   assign bus.inhibit_overrun    = ovr_sticky_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed vector table, corner-case sequences and a random
// phase, all checked every cycle against a transaction-level reference model.
module tb_sdram_arbiter;
   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 16;
   localparam int unsigned MW   = 2;
   localparam int unsigned IMAX = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sdram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) bus ();

   sdram_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .INHIBIT_MAX(IMAX)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: who owns the bus, whether the owner's transfer is outstanding
   // or waiting for the handshake to settle, and a run-length for the inhibit watchdog.
   typedef enum {FREE, OUTSTANDING, SETTLING} phase_e;
   phase_e          m_ph = FREE;
   bit              m_is_h = 1'b0;
   logic            m_acc = 1'b0, m_we = 1'b0;
   logic [AW-1:0]   m_addr = '0;
   logic [DW-1:0]   m_wd = '0, m_rd = '0;
   logic [MW-1:0]   m_sel = '0;
   logic            m_hack = 1'b0, m_lack = 1'b0, m_lidle = 1'b0;
   logic            m_prev_ack = 1'b0, m_trip = 1'b0, m_sticky = 1'b0;
   int              m_run = 0;

   // One clock: the DUT samples the current inputs, the model consumes the same inputs,
   // and every output is compared just after the edge.
   task automatic step();
      logic free_before, inh_prev, owner_en;
      @(posedge clk);
      #1;
      if (reset) begin
         m_ph = FREE; m_acc = 0; m_we = 0; m_addr = '0; m_wd = '0; m_sel = '0; m_rd = '0;
         m_hack = 0; m_lack = 0; m_lidle = 0; m_prev_ack = 0;
         m_trip = 0; m_sticky = 0; m_run = 0;
      end else begin
         free_before = (m_ph == FREE);
         m_hack = 0;
         m_lack = 0;
         if (m_ph == FREE) begin
            if (bus.h_enable || (bus.l_enable && !bus.h_critical)) begin
               m_is_h = bus.h_enable;
               m_we   = m_is_h ? bus.h_we      : bus.l_we;
               m_addr = m_is_h ? bus.h_addr    : bus.l_addr;
               m_wd   = m_is_h ? bus.h_wr_data : bus.l_wr_data;
               m_sel  = m_is_h ? bus.h_wr_mask : bus.l_wr_mask;
               m_acc  = 1;
               m_ph   = OUTSTANDING;
            end
         end else if (m_ph == OUTSTANDING) begin
            if (bus.sd_ack_level && !m_prev_ack) begin
               m_rd = bus.sd_rd_data;
               if (m_is_h) m_hack = 1; else m_lack = 1;
               m_acc = 0;
               m_ph  = SETTLING;
            end
         end else begin
            owner_en = m_is_h ? bus.h_enable : bus.l_enable;
            if (!bus.sd_ack_level && !owner_en) m_ph = FREE;
         end
         m_lidle    = bus.sd_idle && free_before && !bus.h_critical;
         m_prev_ack = bus.sd_ack_level;
         inh_prev   = bus.h_critical && bus.h_refresh_inhibit && !m_trip;
         if (inh_prev) begin
            m_run++;
            if (m_run == IMAX) begin
               m_trip = 1; m_sticky = 1; m_run = 0;
            end
         end else begin
            m_run = 0;
         end
         if (!bus.h_critical) m_trip = 0;
      end
      chk("sd_acc", bus.sd_acc, m_acc);
      chk("sd_we", bus.sd_we, m_we);
      chk("sd_addr", bus.sd_addr, m_addr);
      chk("sd_wr_data", bus.sd_wr_data, m_wd);
      chk("sd_sel", bus.sd_sel, m_sel);
      chk("rd_data", bus.rd_data, m_rd);
      chk("h_ack", bus.h_ack, m_hack);
      chk("l_ack", bus.l_ack, m_lack);
      chk("l_idle", bus.l_idle, m_lidle);
      chk("sd_refresh_inhibit", bus.sd_refresh_inhibit,
          !reset && bus.h_critical && bus.h_refresh_inhibit && !m_trip);
      chk("inhibit_overrun", bus.inhibit_overrun, m_sticky);
   endtask

   task automatic wait_grant(input string name);
      for (int i = 0; i < 20; i++) begin
         if (bus.sd_acc) break;
         step();
      end
      chk(name, bus.sd_acc, 1'b1);
   endtask

   int n_hack = 0, n_lack = 0, n_grant = 0;
   logic acc_prev = 1'b0;
   always @(negedge clk) begin
      if (bus.h_ack) n_hack++;
      if (bus.l_ack) n_lack++;
      if (bus.sd_acc && !acc_prev) n_grant++;
      acc_prev = bus.sd_acc;
   end

   initial begin
      #1ms;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic l_en; logic ack; logic [DW-1:0] rdd;
      logic e_acc; logic e_lack; logic e_hack; logic [DW-1:0] e_rd;
   } vec_t;
   vec_t tbl[9];

   int hs, ls, hcnt, lcnt, rs, rcnt, cnt, h0, l0, g0;

   initial begin
      tbl[0] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
      tbl[1] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
      tbl[2] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
      tbl[3] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
      tbl[4] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
      tbl[5] = '{1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0, 16'hBEEF};
      tbl[6] = '{1'b0, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 16'hBEEF};
      tbl[7] = '{1'b0, 1'b0, 16'h2222, 1'b0, 1'b0, 1'b0, 16'hBEEF};
      tbl[8] = '{1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 16'hBEEF};

      reset = 1;
      bus.h_critical = 0; bus.h_enable = 0; bus.h_we = 0; bus.h_addr = '0;
      bus.h_wr_data = '0; bus.h_wr_mask = '0; bus.h_refresh_inhibit = 0;
      bus.l_enable = 0; bus.l_we = 0; bus.l_addr = '0; bus.l_wr_data = '0; bus.l_wr_mask = '0;
      bus.sd_ack_level = 0; bus.sd_rd_data = '0; bus.sd_idle = 1;
      step(); step();
      chk("reset_sd_acc", bus.sd_acc, 1'b0);
      chk("reset_overrun", bus.inhibit_overrun, 1'b0);
      reset = 0;
      step();

      // Port L read through the vector table
      bus.l_addr = 32'h0000_1234;
      h0 = n_hack;
      foreach (tbl[i]) begin
         bus.l_enable = tbl[i].l_en; bus.sd_ack_level = tbl[i].ack; bus.sd_rd_data = tbl[i].rdd;
         step();
         chk($sformatf("tbl%0d_acc", i), bus.sd_acc, tbl[i].e_acc);
         chk($sformatf("tbl%0d_lack", i), bus.l_ack, tbl[i].e_lack);
         chk($sformatf("tbl%0d_hack", i), bus.h_ack, tbl[i].e_hack);
         chk($sformatf("tbl%0d_rd", i), bus.rd_data, tbl[i].e_rd);
         if (tbl[i].e_acc) chk($sformatf("tbl%0d_addr", i), bus.sd_addr, 32'h0000_1234);
      end
      chk("tbl_no_hack", n_hack - h0, 0);

      // Simultaneous requests: H first, then L, one ack each
      h0 = n_hack; l0 = n_lack;
      bus.h_addr = 32'h8000_0010; bus.l_addr = 32'h0000_0020;
      bus.h_enable = 1; bus.l_enable = 1;
      step();
      chk("both_h_first", bus.sd_addr, 32'h8000_0010);
      step();
      bus.sd_ack_level = 1; bus.sd_rd_data = 16'hC0DE; step();
      bus.h_enable = 0; bus.sd_ack_level = 0;
      wait_grant("both_l_grant");
      chk("both_l_addr", bus.sd_addr, 32'h0000_0020);
      bus.sd_ack_level = 1; bus.sd_rd_data = 16'hD00D; step();
      bus.l_enable = 0; bus.sd_ack_level = 0; step(); step();
      chk("both_one_hack", n_hack - h0, 1);
      chk("both_one_lack", n_lack - l0, 1);

      // h_critical rises while L is in flight
      bus.l_addr = 32'h0000_0440; bus.h_addr = 32'h8000_0440;
      bus.l_enable = 1; step();
      bus.h_critical = 1; bus.h_enable = 1; step(); step();
      chk("crit_still_l", bus.sd_addr, 32'h0000_0440);
      bus.sd_ack_level = 1; bus.sd_rd_data = 16'h5A5A; step();
      chk("crit_l_ack", bus.l_ack, 1'b1);
      bus.l_enable = 0; bus.sd_ack_level = 0; step();
      wait_grant("crit_h_grant");
      chk("crit_h_addr", bus.sd_addr, 32'h8000_0440);
      bus.l_enable = 1;
      bus.sd_ack_level = 1; step();
      chk("crit_h_ack", bus.h_ack, 1'b1);
      bus.h_enable = 0; bus.sd_ack_level = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("crit_l_blocked", bus.sd_acc, 1'b0);
         chk("crit_l_idle", bus.l_idle, 1'b0);
      end
      bus.h_critical = 0;
      wait_grant("crit_l_after");
      chk("crit_l_addr", bus.sd_addr, 32'h0000_0440);
      bus.sd_ack_level = 1; step();
      bus.l_enable = 0; bus.sd_ack_level = 0; step(); step();

      // H write with enable held well past its ack
      g0 = n_grant; h0 = n_hack;
      bus.h_we = 1; bus.h_wr_data = 16'h00A5; bus.h_wr_mask = 2'b01; bus.h_addr = 32'h8000_0100;
      bus.h_enable = 1; step();
      chk("wr_we", bus.sd_we, 1'b1);
      chk("wr_data", bus.sd_wr_data, 16'h00A5);
      chk("wr_sel", bus.sd_sel, 2'b01);
      step(); step();
      bus.sd_ack_level = 1; step();
      bus.sd_ack_level = 0;
      repeat (10) step();
      bus.h_enable = 0; bus.h_we = 0;
      repeat (3) step();
      chk("wr_one_grant", n_grant - g0, 1);
      chk("wr_one_hack", n_hack - h0, 1);

      // Refresh-inhibit watchdog
      bus.h_critical = 1; bus.h_refresh_inhibit = 1;
      #1;
      cnt = int'(bus.sd_refresh_inhibit);
      for (int i = 0; i < 39; i++) begin
         step();
         cnt += int'(bus.sd_refresh_inhibit);
      end
      chk("wd_high_cycles", cnt, IMAX);
      chk("wd_overrun_set", bus.inhibit_overrun, 1'b1);
      bus.h_critical = 0; step();
      chk("wd_overrun_sticky", bus.inhibit_overrun, 1'b1);
      chk("wd_inhibit_low", bus.sd_refresh_inhibit, 1'b0);
      bus.h_refresh_inhibit = 0; step();

      // Reset in the middle of an H transaction
      h0 = n_hack;
      bus.h_addr = 32'h8000_0200; bus.h_enable = 1; step(); step();
      reset = 1; bus.h_enable = 0; step();
      chk("rst_acc_drop", bus.sd_acc, 1'b0);
      chk("rst_no_hack", bus.h_ack, 1'b0);
      reset = 0; step();
      bus.sd_ack_level = 1; step(); step();
      bus.sd_ack_level = 0; step(); step();
      chk("rst_ack_ignored", n_hack - h0, 0);
      bus.l_addr = 32'h0000_0300; bus.l_enable = 1;
      wait_grant("rst_then_l_grant");
      bus.sd_ack_level = 1; step();
      bus.l_enable = 0; bus.sd_ack_level = 0; step(); step();

      // Random phase
      hs = 0; ls = 0; hcnt = 2; lcnt = 0; rs = 0; rcnt = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         reset = ($urandom_range(0, 399) == 0);
         bus.h_critical = ($urandom_range(0, 29) == 0) ? !bus.h_critical : bus.h_critical;
         bus.h_refresh_inhibit = ($urandom_range(0, 3) != 0);
         bus.sd_idle = $urandom_range(0, 1);
         bus.sd_rd_data = DW'($urandom);
         if (reset) begin
            hs = 0; ls = 0; rs = 0; bus.h_enable = 0; bus.l_enable = 0; bus.sd_ack_level = 0;
         end else begin
            case (hs)
               0: if (hcnt > 0) hcnt--; else begin
                     hs = 1; bus.h_enable = 1; bus.h_we = $urandom_range(0, 1);
                     bus.h_addr = {1'b1, 31'($urandom)}; bus.h_wr_data = DW'($urandom);
                     bus.h_wr_mask = MW'($urandom);
                  end
               1: if (bus.h_ack) begin hs = 2; hcnt = $urandom_range(0, 3); end
               default: if (hcnt > 0) hcnt--; else begin
                     hs = 0; bus.h_enable = 0; hcnt = $urandom_range(0, 12);
                  end
            endcase
            case (ls)
               0: if (lcnt > 0) lcnt--; else begin
                     ls = 1; bus.l_enable = 1; bus.l_we = $urandom_range(0, 1);
                     bus.l_addr = {1'b0, 31'($urandom)}; bus.l_wr_data = DW'($urandom);
                     bus.l_wr_mask = MW'($urandom);
                  end
               1: if (bus.l_ack) begin ls = 2; lcnt = $urandom_range(0, 3); end
               default: if (lcnt > 0) lcnt--; else begin
                     ls = 0; bus.l_enable = 0; lcnt = $urandom_range(0, 6);
                  end
            endcase
            case (rs)
               0: if (bus.sd_acc) begin
                     rs = 1; rcnt = $urandom_range(0, 4); bus.sd_ack_level = 0;
                  end else begin
                     bus.sd_ack_level = ($urandom_range(0, 24) == 0);
                  end
               1: if (rcnt > 0) rcnt--; else begin
                     rs = 2; bus.sd_ack_level = 1; rcnt = $urandom_range(0, 2);
                  end
               default: if (rcnt > 0) rcnt--; else begin
                     rs = 0; bus.sd_ack_level = 0;
                  end
            endcase
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Registered two-port arbiter in front of `sdram_ctrl`. Replaces the combinational `spi_critical` mux in the top level.
- Shares the single SDRAM logical interface between the SPI flash emulator (high priority, port H) and the serial user command parser (low priority, port L).
- Routes read data and single-cycle ack pulses back to the owning port.
- Gates refresh inhibit behind a watchdog so refresh can never be blocked forever.

Parameters:
- ADDR_WIDTH, 32, width of the address buses.
- DATA_WIDTH, 16, width of the SDRAM data buses.
- MASK_WIDTH, 2, width of the byte write masks.
- INHIBIT_MAX, 4096, maximum consecutive clk cycles refresh inhibit may be held asserted.

Ports:
- clk  in  1  system clock (132 MHz).
- reset  in  1  synchronous, active-high reset.
- h_critical  in  1  port H owns the bus; new port L grants are blocked while high.
- h_enable  in  1  port H request, held until h_ack.
- h_we  in  1  port H write enable.
- h_addr  in  ADDR_WIDTH  port H address.
- h_wr_data  in  DATA_WIDTH  port H write data.
- h_wr_mask  in  MASK_WIDTH  port H byte mask.
- h_refresh_inhibit  in  1  port H refresh-inhibit request.
- h_ack  out  1  one-cycle completion pulse for port H.
- l_enable  in  1  port L request, held until l_ack.
- l_we  in  1  port L write enable.
- l_addr  in  ADDR_WIDTH  port L address.
- l_wr_data  in  DATA_WIDTH  port L write data.
- l_wr_mask  in  MASK_WIDTH  port L byte mask.
- l_ack  out  1  one-cycle completion pulse for port L.
- l_idle  out  1  controller idle and port L allowed to issue.
- rd_data  out  DATA_WIDTH  registered read data, valid with either ack.
- sd_acc  out  1  controller access request.
- sd_we  out  1  controller write enable.
- sd_addr  out  ADDR_WIDTH  controller address.
- sd_wr_data  out  DATA_WIDTH  controller write data.
- sd_sel  out  MASK_WIDTH  controller byte mask.
- sd_ack_level  in  1  controller ack, level (ack_o).
- sd_rd_data  in  DATA_WIDTH  controller read data.
- sd_idle  in  1  controller idle.
- sd_refresh_inhibit  out  1  gated refresh inhibit to the controller.
- inhibit_overrun  out  1  sticky flag: watchdog fired.

Behaviour:
- Reset: all outputs 0; state IDLE; watchdog counter 0; inhibit_overrun cleared.
- State machine:
  - IDLE:
    - If h_enable: latch H request fields into the sd_* registers, sd_acc<=1, go BUSY_H.
    - Else if l_enable && !h_critical: latch L fields, sd_acc<=1, go BUSY_L.
    - H wins when both request in the same cycle.
    - Request seen in cycle N gives sd_acc=1 in cycle N+1.
  - BUSY_x:
    - Hold sd_acc and all latched fields stable.
    - On the rising edge of sd_ack_level (level high, previous sample low): rd_data<=sd_rd_data, x_ack<=1 for exactly one cycle, sd_acc<=0, go RELEASE_x.
    - Ack is visible one cycle after the rising edge.
  - RELEASE_x:
    - Wait until sd_ack_level==0 and x_enable==0, then go IDLE.
    - Prevents a held enable from re-issuing the same request.
    - If x_enable is still high on leaving RELEASE_x, no new grant is made for that port until it drops.
- No preemption: an L transaction in flight when h_critical rises completes normally. H is granted from the next IDLE.
- h_critical has no effect on an H request; H is always granted from IDLE.
- Ack isolation: l_ack is never asserted during BUSY_H or RELEASE_H, and the reverse holds for h_ack.
- A spurious sd_ack_level rising edge in IDLE is ignored; no ack is generated.
- l_idle = sd_idle && state==IDLE && !h_critical, registered one cycle.
- Refresh inhibit:
  - sd_refresh_inhibit = h_critical && h_refresh_inhibit && !overrun_active.
  - The counter increments each cycle sd_refresh_inhibit is high and clears when it is low.
  - When the counter reaches INHIBIT_MAX-1: set overrun_active and inhibit_overrun. sd_refresh_inhibit drops the next cycle.
  - overrun_active clears when h_critical falls. inhibit_overrun stays sticky until reset.
  - The counter saturates and never wraps.
- Reset mid-transaction: return to IDLE, drop sd_acc immediately, no ack issued. The controller's own reset is handled separately.

Test Plan:
- Port L read, addr=0x1234, sd_rd_data=0xBEEF, ack 5 cycles after sd_acc -> sd_acc high cycle N+1; l_ack one pulse; rd_data=0xBEEF; h_ack never asserts.
- h_enable and l_enable rise in the same cycle -> H served first (sd_addr=h_addr); L served after H release, with a single ack each.
- L transaction in flight, h_critical rises mid-way -> L completes with l_ack; H then granted; further L blocked while h_critical=1; l_idle=0.
- Port H write, we=1, wr_data=0x00A5, mask=2'b01, enable held 10 cycles after ack -> exactly one sd_acc pulse train, one h_ack, no re-issue.
- INHIBIT_MAX=16, h_critical and h_refresh_inhibit held high 40 cycles -> sd_refresh_inhibit high 16 cycles then 0; inhibit_overrun=1 stays set after h_critical falls.
- Reset asserted during BUSY_H -> next cycle sd_acc=0, state IDLE, no h_ack; a later ack edge is ignored.
